// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer slice.
//   state_t      : controller states (IDLE, RUN, PAUSE, DONE)
//   COUNT_W      : width of the count bus feeding the segment converter
//   MAX_COUNT    : largest value the downstream converter accepts
//   clamp_count  : saturates a requested load value to MAX_COUNT
package countdown_timer_pkg;

  localparam int unsigned COUNT_W   = 7;
  localparam int unsigned MAX_COUNT = 29;

  localparam logic [COUNT_W-1:0] MAX_COUNT_V = COUNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] v);
    return (v > MAX_COUNT_V) ? MAX_COUNT_V : v;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler producing one tick every TICK_DIV enabled cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset, prescaler -> 0
//   en   : advance the prescaler this cycle
//   clr  : force the prescaler to 0 (overrides en)
//   tick : high in the enabled cycle where the prescaler wraps
module countdown_timer_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A divide-by-one still needs a 1-bit register; it simply never leaves 0.
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre <= '0;
    end else if (en) begin
      if (pre == LAST) begin
        pre <= '0;
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  assign tick = en && !clr && (pre == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Loadable 0..29 countdown timer with a one-second tick prescaler.
//   clk      : system clock (rising edge)
//   rst      : synchronous active-high reset
//   start    : begin / resume counting
//   pause    : freeze counting while running
//   load     : load load_val when not running
//   load_val : value to load, saturated to 29
//   count    : current value, always 0..29 (registered)
//   running  : high only in RUN (registered)
//   done     : one-cycle pulse as count reaches 0 from RUN (registered)
// Control priority each cycle: rst > load > pause > start.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned START_VAL = 29
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               done
);

  localparam logic [COUNT_W-1:0] START_CNT = COUNT_W'(START_VAL);

  state_t state;

  logic tick;
  logic tick_en;
  logic tick_clr;
  logic load_ok;
  logic restart;

  always_comb begin
    load_ok  = 1'b0;
    restart  = 1'b0;
    tick_en  = 1'b0;
    tick_clr = 1'b0;
    // Load is ignored while running; elsewhere it beats pause and start.
    load_ok  = load && (state != RUN);
    // A start out of IDLE or DONE begins a fresh second; a resume from
    // PAUSE keeps the partially elapsed prescaler value.
    restart  = !load_ok && !pause && start && ((state == IDLE) || (state == DONE));
    // No tick in the cycle pause is sampled, so the prescaler holds.
    tick_en  = (state == RUN) && !pause;
    tick_clr = load_ok || restart;
  end

  countdown_timer_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= START_CNT;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_ok) begin
            count <= clamp_count(load_val);
          end else if (restart) begin
            if (count == '0) begin
              count <= START_CNT;
            end
            state   <= RUN;
            running <= 1'b1;
          end
        end

        RUN: begin
          if (pause) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick && (count != '0)) begin
            count <= count - COUNT_W'(1);
            if (count == COUNT_W'(1)) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end

        PAUSE: begin
          if (load_ok) begin
            count <= clamp_count(load_val);
            state <= IDLE;
          end else if (!pause && start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        DONE: begin
          if (load_ok) begin
            count <= clamp_count(load_val);
            state <= IDLE;
          end else if (restart) begin
            count   <= START_CNT;
            state   <= RUN;
            running <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
